// File: rtl/bram_add_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bram_add_pkg
// Description : Shared state encoding and constants for the BRAM pair-add
//               sequencer and its adder.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_add_pkg;

    // Sequencer states; one pair walks RD_A -> RD_B -> ADD -> WR
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        ADD  = 3'd3,
        WR   = 3'd4,
        FIN  = 3'd5
    } state_t;

    // Offset of operand B from operand A inside the input BRAM
    localparam int HALF      = 32;
    // Operand width and full-carry result width
    localparam int DATA_W    = 8;
    localparam int SUM_W     = 9;
    // A pairs value of zero selects this many pairs
    localparam int MAX_PAIRS = 32;

endpackage : bram_add_pkg
`default_nettype wire

// File: rtl/add8_c9.sv
`default_nettype none
// ============================================================================
// Module      : add8_c9
// Description : 8-bit ripple-carry adder made of 1-bit full-adder cells,
//               carry-in fixed at zero, 9-bit result (carry in the MSB).
// Revision    : 1.0 - initial release
// ============================================================================
module add8_c9
    import bram_add_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [SUM_W-1:0]  sum
);

    logic [DATA_W:0] carry;

    assign carry[0] = 1'b0;

    // One full-adder cell per bit, carry rippling from LSB to MSB
    generate
        for (genvar i = 0; i < DATA_W; i++) begin : g_fa
            logic half_x;
            assign half_x       = a[i] ^ b[i];
            assign sum[i]       = half_x ^ carry[i];
            assign carry[i + 1] = (a[i] & b[i]) | (half_x & carry[i]);
        end
    endgenerate

    // Final carry becomes the 9th result bit, so the sum never overflows
    assign sum[SUM_W-1] = carry[DATA_W];

endmodule : add8_c9
`default_nettype wire

// File: rtl/bram_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bram_add_sequencer
// Description : Reads operand pairs A[k], B[k+HALF] from an input BRAM,
//               adds them to a 9-bit result and writes it to out[k], for
//               k walking ascending or descending over n pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_add_sequencer #(
    parameter int ADDR_W = 6,
    parameter int HALF   = bram_add_pkg::HALF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dir,
    input  logic [5:0]        pairs,
    output logic              busy,
    output logic              done,
    output logic              in_wen,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_dout,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_addr,
    output logic [8:0]        out_din
);

    import bram_add_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] k;
    logic [5:0]        n;
    logic              dir_q;
    logic [7:0]        a_reg;
    logic [8:0]        sum_reg;
    logic [8:0]        sum_w;
    logic [5:0]        n_start;
    logic              last_pair;

    // Pair count requested at start; zero encodes the full 32 pairs
    assign n_start   = (pairs == 6'd0) ? 6'(MAX_PAIRS) : pairs;
    // The final pair sits at the far end of the walk direction
    assign last_pair = dir_q ? (k == '0) : (k == ADDR_W'(n - 6'd1));

    assign in_wen  = 1'b0;
    assign out_din = sum_reg;

    add8_c9 u_add (
        .a   (a_reg),
        .b   (in_dout),
        .sum (sum_w)
    );

    // State register with immediate return to IDLE on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-driven outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        out_wen   = 1'b0;
        in_addr   = k;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = RD_A;
                end
            end
            RD_A: state_nxt = RD_B;
            RD_B: begin
                in_addr   = k + ADDR_W'(HALF);
                state_nxt = ADD;
            end
            ADD:  state_nxt = WR;
            WR: begin
                out_wen   = 1'b1;
                state_nxt = last_pair ? FIN : RD_A;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job parameters, pair index and the operand/result pipeline registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k        <= '0;
            n        <= '0;
            dir_q    <= 1'b0;
            a_reg    <= '0;
            sum_reg  <= '0;
            out_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q <= dir;
                        n     <= n_start;
                        k     <= dir ? ADDR_W'(n_start - 6'd1) : '0;
                    end
                end
                RD_B: a_reg <= in_dout;
                ADD: begin
                    sum_reg  <= sum_w;
                    out_addr <= k;
                end
                WR: begin
                    if (!last_pair) begin
                        k <= dir_q ? (k - ADDR_W'(1)) : (k + ADDR_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : bram_add_sequencer
`default_nettype wire

// File: tb/tb_bram_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_add_sequencer
// Description : Self-checking bench for bram_add_sequencer with BRAM models,
//               table vectors, corner sequences and random jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_add_sequencer;

    localparam int ADDR_W = 6;
    localparam int HALF   = 32;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b1;
    logic              start   = 1'b0;
    logic              dir     = 1'b0;
    logic [5:0]        pairs   = '0;
    logic              busy;
    logic              done;
    logic              in_wen;
    logic [ADDR_W-1:0] in_addr;
    logic [7:0]        in_dout = '0;
    logic              out_wen;
    logic [ADDR_W-1:0] out_addr;
    logic [8:0]        out_din;

    int checks = 0;
    int errors = 0;

    logic [7:0] in_mem  [64];
    logic [8:0] out_mem [64];

    int wa[$];
    int wd[$];
    int busy_n;
    int done_cyc;
    int done_n;
    int bad_addr;
    int cur_n;

    typedef struct {
        bit         d;
        logic [5:0] p;
        logic [7:0] fa;
        logic [7:0] fb;
        int         exp_n;
        int         exp_sum;
        int         exp_first;
    } vec_t;

    vec_t tbl [5];

    bram_add_sequencer #(.ADDR_W(ADDR_W), .HALF(HALF)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dir      (dir),
        .pairs    (pairs),
        .busy     (busy),
        .done     (done),
        .in_wen   (in_wen),
        .in_addr  (in_addr),
        .in_dout  (in_dout),
        .out_wen  (out_wen),
        .out_addr (out_addr),
        .out_din  (out_din)
    );

    always #5 clk = ~clk;

    // Input BRAM: one-cycle read latency
    always @(posedge clk) in_dout <= in_mem[in_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_out();
        for (int i = 0; i < 64; i++) out_mem[i] = '0;
    endtask

    // Runs one job from the current negedge; start pulses at cycles ign_a/ign_b
    task automatic run_job(input bit d, input logic [5:0] p, input int ign_a, input int ign_b);
        int cyc;
        wa.delete();
        wd.delete();
        busy_n   = 0;
        done_cyc = -1;
        done_n   = 0;
        bad_addr = 0;
        cur_n    = (p == 6'd0) ? 32 : int'(p);
        dir      = d;
        pairs    = p;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 300) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_wen) begin
                wa.push_back(int'(out_addr));
                wd.push_back(int'(out_din));
                out_mem[out_addr] = out_din;
            end
            if (busy && !((int'(in_addr) < cur_n) ||
                          (int'(in_addr) >= HALF && int'(in_addr) < HALF + cur_n)))
                bad_addr++;
            if (done_cyc >= 0) break;
            start = (cyc == ign_a) || (cyc == ign_b);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", {31'd0, done}, 32'd0);
        chk("busy_after_job", {31'd0, busy}, 32'd0);
    endtask

    // Reference: pair i touches k = i (ascending) or n-1-i (descending), out = A+B
    task automatic check_model(input bit d);
        int k;
        int e;
        chk("busy_cycles", busy_n, 4 * cur_n + 1);
        chk("done_latency", done_cyc, 4 * cur_n + 1);
        chk("done_count", done_n, 1);
        chk("write_count", wa.size(), cur_n);
        chk("addr_range", bad_addr, 0);
        for (int i = 0; i < cur_n; i++) begin
            k = d ? (cur_n - 1 - i) : i;
            e = int'(in_mem[k]) + int'(in_mem[k + HALF]);
            if (i < wa.size()) begin
                chk("write_addr", wa[i], k);
                chk("write_data", wd[i], e);
            end
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) in_mem[i] = 8'($urandom);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int nw;
        int ostuck;
        int bad;
        bit rd;
        logic [5:0] rp;

        tbl[0] = '{1'b0, 6'd1,  8'd1,   8'd2,   1,  3,   0};
        tbl[1] = '{1'b1, 6'd0,  8'hFF,  8'h01,  32, 256, 31};
        tbl[2] = '{1'b0, 6'd32, 8'hFF,  8'hFF,  32, 510, 0};
        tbl[3] = '{1'b1, 6'd5,  8'h80,  8'h80,  5,  256, 4};
        tbl[4] = '{1'b1, 6'd1,  8'h00,  8'h00,  1,  0,   0};

        for (int i = 0; i < 64; i++) in_mem[i] = '0;
        clear_out();

        // Reset state without any clock edge
        #1 reset_n = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_out_wen", {31'd0, out_wen}, 0);
        chk("rst_in_wen", {31'd0, in_wen}, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_din", out_din, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Ascending reference job
        in_mem[0] = 8'd10;  in_mem[1] = 8'd20;  in_mem[2] = 8'd255; in_mem[3] = 8'd0;
        in_mem[32] = 8'd5;  in_mem[33] = 8'd235; in_mem[34] = 8'd255; in_mem[35] = 8'd0;
        run_job(1'b0, 6'd4, -1, -1);
        check_model(1'b0);
        chk("asc_out0", out_mem[0], 15);
        chk("asc_out1", out_mem[1], 255);
        chk("asc_out2", out_mem[2], 510);
        chk("asc_out3", out_mem[3], 0);

        // Descending job on the same data, back-to-back with the previous one
        clear_out();
        run_job(1'b1, 6'd4, -1, -1);
        check_model(1'b1);
        chk("desc_first_addr", (wa.size() > 0) ? wa[0] : -1, 3);
        chk("desc_out0", out_mem[0], 15);
        chk("desc_out1", out_mem[1], 255);
        chk("desc_out2", out_mem[2], 510);
        chk("desc_out3", out_mem[3], 0);

        // Start pulses during a running job must be ignored
        run_job(1'b0, 6'd4, 3, 9);
        check_model(1'b0);

        // Table vectors: uniform fills
        foreach (tbl[t]) begin
            for (int i = 0; i < HALF; i++) begin
                in_mem[i]        = tbl[t].fa;
                in_mem[i + HALF] = tbl[t].fb;
            end
            run_job(tbl[t].d, tbl[t].p, -1, -1);
            check_model(tbl[t].d);
            chk("tbl_count", wa.size(), tbl[t].exp_n);
            chk("tbl_first_addr", (wa.size() > 0) ? wa[0] : -1, tbl[t].exp_first);
            bad = 0;
            foreach (wd[w]) if (wd[w] != tbl[t].exp_sum) bad++;
            chk("tbl_sum", bad, 0);
        end

        // Reset during ADD of pair 2 aborts the job
        fill_rand();
        dir   = 1'b0;
        pairs = 6'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nw = 0;
        repeat (10) begin
            if (out_wen) nw++;
            @(negedge clk);
        end
        chk("abort_pre_busy", {31'd0, busy}, 1);
        chk("abort_pre_writes", nw, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_out_wen", {31'd0, out_wen}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_in_addr", in_addr, 0);
        chk("abort_out_din", out_din, 0);
        ostuck = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_wen || done || busy) ostuck++;
        end
        chk("abort_quiet", ostuck, 0);
        reset_n = 1'b1;
        run_job(1'b1, 6'd3, -1, -1);
        check_model(1'b1);

        // Random jobs against the reference
        for (int r = 0; r < 8; r++) begin
            fill_rand();
            rd = 1'($urandom_range(0, 1));
            rp = 6'($urandom_range(0, 32));
            run_job(rd, rp, int'($urandom_range(2, 20)), -1);
            check_model(rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bram_add_sequencer
`default_nettype wire

// File: doc/bram_add_sequencer.md
BRAM_ADD_SEQUENCER -- requirements
Module: bram_add_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving the BRAM address width.
REQ-002 The block SHALL have parameter HALF, default 32, giving the address offset of operand B from operand A.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: single-cycle request to begin a job; sampled in IDLE only.
REQ-006 Port dir, input, 1 bit: processing order, 0 = ascending, 1 = descending; captured at start.
REQ-007 Port pairs, input, 6 bits: number of pairs to process, 1..32, with 0 meaning 32; captured at start.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE.
REQ-009 Port done, output, 1 bit: one-cycle pulse when a job completes.
REQ-010 Port in_wen, output, 1 bit: input BRAM write enable, tied to 0.
REQ-011 Port in_addr, output, ADDR_W bits: input BRAM read address.
REQ-012 Port in_dout, input, 8 bits: input BRAM read data.
REQ-013 Port out_wen, output, 1 bit: output BRAM write enable.
REQ-014 Port out_addr, output, ADDR_W bits: output BRAM write address.
REQ-015 Port out_din, output, 9 bits: output BRAM write data.

Function
REQ-016 Input BRAM read latency SHALL be exactly 1 cycle: in_dout reflects the in_addr presented in the previous cycle.
REQ-017 FSM states SHALL be IDLE, RD_A, RD_B, ADD, WR, FIN.
- IDLE, start=1: go to RD_A; latch dir; latch n = (pairs==0 ? 32 : pairs); k = dir ? n-1 : 0.
- RD_A: in_addr = k; go to RD_B.
- RD_B: in_addr = k+HALF; latch a_reg = in_dout; go to ADD.
- ADD: sum_reg = a_reg + in_dout, a full 9-bit result with the carry in bit 8; go to WR.
- WR: out_wen = 1, out_addr = k, out_din = sum_reg. If this is the last pair, go to FIN; otherwise step k by +1 (ascending) or -1 (descending) and go to RD_A.
- FIN: done = 1; go to IDLE.
REQ-018 Each pair SHALL take exactly 4 cycles; a job of n pairs SHALL hold busy for 4n+1 cycles, from the cycle after start through FIN.
REQ-019 out_wen SHALL be high only in WR, for exactly one cycle per pair.
REQ-020 start SHALL be ignored when it arrives in any state other than IDLE.
REQ-021 The last pair SHALL be k = n-1 when ascending and k = 0 when descending.
REQ-022 k SHALL never wrap: no address outside 0..n-1 (operand A) or HALF..HALF+n-1 (operand B) is ever driven.
REQ-023 The sum SHALL never overflow; 255+255 = 0x1FE.
REQ-024 out_addr and out_din SHALL hold their last values outside WR; only out_wen qualifies them.
REQ-025 Writes SHALL have no read-back dependency: the block never reads the output BRAM.

Reset
REQ-026 When reset_n is low, the block SHALL immediately enter IDLE, with no clock edge required.
REQ-027 During and after reset, busy, done and out_wen SHALL be 0, and in_addr, out_addr, out_din, k, a_reg, sum_reg and n SHALL be 0.
REQ-028 Reset asserted mid-job SHALL abort the job without issuing any further write, and SHALL NOT produce a done pulse.
REQ-029 On reset release, the first start SHALL be accepted on the first rising edge at which reset_n is high.

Structure
REQ-030 A shared package bram_add_pkg SHALL hold the state enumeration and the constants HALF and the 9-bit result width.
REQ-031 The add SHALL be one sub-module, add8_c9: an 8-bit ripple-carry adder built from 1-bit full-adder cells, with cin = 0 and a 9-bit result.
REQ-032 in_dout SHALL be registered only through a_reg and sum_reg; there SHALL be no combinational path from in_dout to out_din.

Verification
REQ-033 Ascending job: preload A[0..3] = 10,20,255,0 and B[32..35] = 5,235,255,0; start with pairs=4, dir=0 -> out[0..3] = 15,255,510,0; exactly 4 out_wen pulses; done rises 17 cycles after start.
REQ-034 Descending job: same data, dir=1, pairs=4 -> write addresses are 3,2,1,0 in that order; final memory contents identical to REQ-033.
REQ-035 Full job: pairs=0, all A = 0xFF, all B = 0x01 -> 32 writes of 0x100 to addresses 0..31; busy high for 129 cycles; no address above 63 driven.
REQ-036 Start pulsed at cycles 3 and 9 of a running job -> both ignored; write count and done timing unchanged.
REQ-037 reset_n dropped during the ADD state of pair 2 -> busy, out_wen and done fall to 0 asynchronously; no further writes; a new start after release runs a clean job.
REQ-038 Back-to-back jobs: start asserted in the cycle after done -> the second job is accepted and runs correctly.
